// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch buffer.
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned INSTR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO of {pc, instr} entries with a synchronous clear that overrides push/pop.
module fetch_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !clear;
        do_pop   = pop && !clear && !empty;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_buffer.sv
// Fetch responder: one outstanding memory read at a time, results queued in order,
// with a flush that discards queued entries and any in-flight read.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               addr_valid,
    input  logic [ADDR_W-1:0]  addr,
    output logic               addr_ready,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               flush
);

    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    fetch_state_t        state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                fifo_push;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;

    assign addr_ready = (state_q == IDLE) && (fifo_count < CNT_W'(DEPTH)) && !flush;
    assign accept     = addr_valid && addr_ready;

    // A request cannot be withdrawn, so a flush mid-read parks in DROP until the ack.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fifo_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_addr_d = addr;
                    mem_req_d  = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    fifo_push = !flush;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({mem_addr_q, mem_rdata}),
        .pop       (instr_ready),
        .clear     (flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Acceptance is gated on space, so a push can never land on a full FIFO.
    assert property (@(posedge clk) disable iff (!reset) !(fifo_push && fifo_full));

    assign mem_req           = mem_req_q;
    assign mem_addr          = mem_addr_q;
    assign instr_valid       = !fifo_empty;
    assign {instr_pc, instr} = fifo_head;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       addr_valid;
    logic [7:0] addr;
    logic       addr_ready;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       flush;

    int checks   = 0;
    int failures = 0;

    // Reference model: expected FIFO contents and the outstanding read.
    fetch_entry_t exp_q[$];
    bit           m_req  = 1'b0;
    bit           m_keep = 1'b0;
    logic [7:0]   m_addr = 8'h00;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(8), .INSTR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_valid  (addr_valid),
        .addr        (addr),
        .addr_ready  (addr_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .flush       (flush)
    );

    function automatic void model_reset();
        exp_q.delete();
        m_req  = 1'b0;
        m_keep = 1'b0;
        m_addr = 8'h00;
    endfunction

    // Applies the effect of the coming clock edge, given the current inputs.
    function automatic void model_edge();
        bit acc;
        bit pop;
        bit ackd;
        fetch_entry_t e;
        if (!reset) begin
            model_reset();
            return;
        end
        acc  = addr_valid && !m_req && (exp_q.size() < DEPTH) && !flush;
        pop  = instr_ready && (exp_q.size() != 0) && !flush;
        ackd = mem_ack && m_req;
        if (flush) begin
            exp_q.delete();
            m_keep = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (ackd && m_keep) begin
                e.pc    = m_addr;
                e.instr = mem_rdata;
                exp_q.push_back(e);
            end
        end
        if (ackd) begin
            m_req  = 1'b0;
            m_keep = 1'b0;
        end
        if (acc) begin
            m_req  = 1'b1;
            m_keep = 1'b1;
            m_addr = addr;
        end
    endfunction

    task automatic advance();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; addr_valid = 1'b1; addr = 8'h5A; mem_ack = 1'b0;
        mem_rdata = 8'h00; instr_ready = 1'b0; flush = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        checks++; if ({instr, instr_pc} !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h/%h exp=00/00", instr, instr_pc); end
        checks++; if (addr_ready !== 1'b1) begin failures++; $display("FAIL reset_addr_ready got=%b exp=1", addr_ready); end
        repeat (3) advance();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_no_capture got=%b exp=0", mem_req); end
        reset = 1'b1; addr_valid = 1'b0;
        repeat (3) advance();
        checks++; if (mem_req !== 1'b0 || addr_ready !== 1'b1) begin
            failures++; $display("FAIL reset_idle req=%b ready=%b exp=0/1", mem_req, addr_ready); end
    endtask

    task automatic test_single_fetch();
        addr_valid = 1'b1; addr = 8'h10;
        advance();
        addr_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin
            failures++; $display("FAIL single_req req=%b addr=%h exp=1/10", mem_req, mem_addr); end
        repeat (2) advance();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", instr_valid); end
        mem_ack = 1'b1; mem_rdata = 8'hA5;
        advance();
        mem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 8'hA5 || instr_pc !== 8'h10) begin
            failures++; $display("FAIL single_data v=%b instr=%h pc=%h exp=1/a5/10", instr_valid, instr, instr_pc); end
        checks++; if (mem_req !== 1'b0 || addr_ready !== 1'b1) begin
            failures++; $display("FAIL single_idle req=%b ready=%b exp=0/1", mem_req, addr_ready); end
        instr_ready = 1'b1;
        advance();
        instr_ready = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL single_pop got=%b exp=0", instr_valid); end
    endtask

    task automatic test_fill();
        logic [7:0] next_a;
        logic [7:0] got[$];
        next_a = 8'h00; instr_ready = 1'b0; flush = 1'b0;
        repeat (14) begin
            addr_valid = (next_a <= 8'h04); addr = next_a;
            mem_ack = mem_req; mem_rdata = 8'h80 + mem_addr;
            #1;
            if (addr_valid && addr_ready) next_a++;
            advance();
        end
        addr_valid = 1'b1; addr = next_a; mem_ack = 1'b0;
        #1;
        checks++; if (next_a !== 8'h04) begin failures++; $display("FAIL fill_accepted got=%0d exp=4", next_a); end
        checks++; if (addr_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%b exp=0", addr_ready); end
        for (int c = 0; c < 30 && got.size() < 5; c++) begin
            addr_valid = (next_a <= 8'h04); addr = next_a;
            mem_ack = mem_req; mem_rdata = 8'h80 + mem_addr; instr_ready = 1'b1;
            #1;
            if (instr_valid) begin
                got.push_back(instr);
                checks++; if (instr_pc !== instr - 8'h80) begin
                    failures++; $display("FAIL fill_pc got=%h exp=%h", instr_pc, instr - 8'h80); end
            end
            if (addr_valid && addr_ready) next_a++;
            advance();
            if (c == 0) begin
                checks++; if (addr_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_after_pop got=%b exp=1", addr_ready); end
            end
        end
        addr_valid = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        checks++; if (got.size() != 5) begin failures++; $display("FAIL fill_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++; if (got[i] !== 8'h80 + 8'(i)) begin failures++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, got[i], 8'h80 + 8'(i)); end
        end
    endtask

    task automatic test_flush_wait();
        addr_valid = 1'b1; addr = 8'h20;
        advance();
        addr_valid = 1'b0; flush = 1'b1;
        #1;
        checks++; if (addr_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", addr_ready); end
        advance();
        flush = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h20 || addr_ready !== 1'b0) begin
            failures++; $display("FAIL flush_drop req=%b addr=%h ready=%b exp=1/20/0", mem_req, mem_addr, addr_ready); end
        advance();
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        advance();
        mem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || addr_ready !== 1'b1) begin
            failures++; $display("FAIL flush_discard v=%b req=%b ready=%b exp=0/0/1", instr_valid, mem_req, addr_ready); end
        addr_valid = 1'b1; addr = 8'hAA;
        advance();
        addr_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h3C;
        advance();
        mem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 8'h3C || instr_pc !== 8'hAA) begin
            failures++; $display("FAIL flush_refetch v=%b instr=%h pc=%h exp=1/3c/aa", instr_valid, instr, instr_pc); end
        instr_ready = 1'b1;
        advance();
        instr_ready = 1'b0;
    endtask

    // Randomized traffic; every cycle compares the DUT against the reference model.
    task automatic test_random(input bit allow_flush, input int n_fetch, input int max_cycles);
        int issued;
        int delivered;
        issued = 0; delivered = 0;
        for (int c = 0; c < max_cycles && (allow_flush || delivered < n_fetch); c++) begin
            addr_valid  = (issued < n_fetch) && ($urandom_range(0, 3) != 0);
            addr        = 8'($urandom);
            mem_ack     = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            mem_rdata   = 8'($urandom);
            instr_ready = ($urandom_range(0, 1) == 1);
            flush       = allow_flush && ($urandom_range(0, 11) == 0);
            #1;
            checks++; if (mem_req !== m_req) begin failures++; $display("FAIL rnd_mem_req c=%0d got=%b exp=%b", c, mem_req, m_req); end
            if (m_req) begin
                checks++; if (mem_addr !== m_addr) begin failures++; $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, mem_addr, m_addr); end
            end
            checks++; if (instr_valid !== (exp_q.size() != 0)) begin
                failures++; $display("FAIL rnd_instr_valid c=%0d got=%b exp=%b", c, instr_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++; if (instr !== exp_q[0].instr || instr_pc !== exp_q[0].pc) begin
                    failures++; $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h", c, instr, instr_pc, exp_q[0].instr, exp_q[0].pc); end
            end
            checks++; if (addr_ready !== (!m_req && exp_q.size() < DEPTH && !flush)) begin
                failures++; $display("FAIL rnd_addr_ready c=%0d got=%b", c, addr_ready); end
            if (addr_valid && !m_req && exp_q.size() < DEPTH && !flush) issued++;
            if (instr_ready && exp_q.size() != 0 && !flush) delivered++;
            advance();
        end
        addr_valid = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; flush = 1'b0;
        if (!allow_flush) begin
            checks++; if (delivered != n_fetch) begin failures++; $display("FAIL rnd_delivered got=%0d exp=%0d", delivered, n_fetch); end
        end
    endtask

    task automatic test_async_reset();
        flush = 1'b1; mem_ack = 1'b1; addr_valid = 1'b0; instr_ready = 1'b0;
        advance();
        flush = 1'b0; mem_ack = 1'b0; addr_valid = 1'b1; addr = 8'h33;
        advance();
        addr_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h77;
        advance();
        mem_ack = 1'b0; addr_valid = 1'b1; addr = 8'h40;
        advance();
        addr_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || instr_valid !== 1'b1) begin
            failures++; $display("FAIL areset_pre req=%b v=%b exp=1/1", mem_req, instr_valid); end
        #1 reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin
            failures++; $display("FAIL areset_req req=%b addr=%h exp=0/00", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b0 || addr_ready !== 1'b1) begin
            failures++; $display("FAIL areset_fifo v=%b ready=%b exp=0/1", instr_valid, addr_ready); end
        advance();
        reset = 1'b1;
        advance();
        checks++; if (instr_valid !== 1'b0 || addr_ready !== 1'b1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL areset_after v=%b ready=%b req=%b exp=0/1/0", instr_valid, addr_ready, mem_req); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_fill();
        test_flush_wait();
        test_random(1'b0, 10, 400);
        test_random(1'b1, 1000, 300);
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-fetch responder between the program counter and the control unit. Accepts one 8-bit fetch address at a time from the PC side and issues it to instruction memory over a req/ack handshake. Queues returned instructions, each tagged with its address, in a small in-order FIFO. On a taken branch (`flush`) it discards all queued and in-flight instructions.

## Interface
- `DEPTH`, default 4: FIFO entries; a power of 2, at least 2.
- `ADDR_W`, default 8: address width.
- `INSTR_W`, default 8: instruction width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `addr_valid`  in  1  the PC side presents a fetch address.
- `addr`  in  ADDR_W  fetch address.
- `addr_ready`  out  1  the block accepts `addr` this cycle.
- `mem_req`  out  1  memory read request; held until `mem_ack`.
- `mem_addr`  out  ADDR_W  memory read address; stable while `mem_req` is high.
- `mem_ack`  in  1  the memory returns `mem_rdata` this cycle.
- `mem_rdata`  in  INSTR_W  instruction from memory.
- `instr_valid`  out  1  the FIFO head is valid.
- `instr`  out  INSTR_W  FIFO head instruction.
- `instr_pc`  out  ADDR_W  address of the FIFO head instruction.
- `instr_ready`  in  1  the consumer pops the head this cycle.
- `flush`  in  1  taken branch; discard everything.

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding, data to be kept.
  - DROP: request outstanding, data to be discarded.
- Address acceptance:
  - `addr_ready` = (state==IDLE) && (count<DEPTH) && !flush. This is combinational.
  - An address is accepted when `addr_valid` && `addr_ready`.
- IDLE, address accepted: capture `addr` into `mem_addr`, set `mem_req`, go to WAIT.
- WAIT, `mem_ack` && !flush: push {`mem_addr`, `mem_rdata`}, clear `mem_req`, go to IDLE.
- WAIT, `mem_ack` && flush: discard the data, clear `mem_req`, go to IDLE.
- WAIT, !`mem_ack` && flush: go to DROP; `mem_req` stays high, because the memory protocol forbids withdrawing a request.
- DROP, `mem_ack`: discard the data, clear `mem_req`, go to IDLE. A `flush` in DROP has no additional effect.
- `flush` sets count to 0 and both pointers to 0 on that edge. A pop or push in the same cycle is ignored.
- Push and pop in the same cycle with the FIFO non-empty: count unchanged, both pointers advance.
- Pop while empty (`instr_valid`=0) is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Acceptance while full is impossible, because `addr_ready`=0. The FIFO therefore never overflows.
- Addresses are opaque and not incremented. Ordering is strictly the order of acceptance.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=0.
  - `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - State IDLE, count 0.
  - `addr_ready` reads 1 while reset is low. No flop captures during reset.
- Reset asserted mid-operation clears everything immediately. `mem_req` falls asynchronously and any in-flight data is lost.
- Address accepted at edge N: `mem_req` is high from cycle N+1.
- `mem_ack` may arrive in the first cycle `mem_req` is high.
- `mem_ack` sampled at edge M:
  - `instr_valid`=1 with the new data from cycle M+1 (if the FIFO was empty).
  - `addr_ready` may be 1 again from cycle M+1.
- Maximum throughput is one fetch per 2 cycles with a zero-wait memory.
- `instr` and `instr_pc` are driven from the head entry, read combinationally from the FIFO storage. They are stable while `instr_valid`=1 and there is no pop or flush.
- `flush` at edge F: `instr_valid`=0 from cycle F+1.
- `mem_ack` while state is IDLE is a protocol error and is ignored.

## Structure
- Shared package `fetch_pkg`:
  - State enum `fetch_state_t` (IDLE, WAIT, DROP).
  - Default width constants `ADDR_W_DEF`=8, `INSTR_W_DEF`=8.
  - Entry struct `fetch_entry_t` {pc, instr}.
- Sub-module `fetch_fifo`:
  - Parameterised DEPTH/width storage with push, pop and clear inputs.
  - Outputs: head, count, full and empty.
  - The top level holds the FSM, the request register and the `addr_ready` logic.

## Test plan
- Reset check: assert reset -> all outputs 0, `addr_ready`=1. After release, with no stimulus, the state stays IDLE and `mem_req`=0.
- Single fetch: `addr`=0x10 accepted, `mem_ack` 2 cycles after `mem_req` rises with `mem_rdata`=0xA5 -> `instr_valid` one cycle after ack, with `instr`=0xA5 and `instr_pc`=0x10.
- Fill with DEPTH=4:
  - Stimulus: `instr_ready`=0, addresses 0x00..0x04 offered, zero-wait ack returning data 0x80+addr.
  - Required: 4 accepted, then `addr_ready`=0.
  - Then `instr_ready`=1: pops in order give 0x80..0x83, and 0x04 is accepted after the first pop.
- Flush in WAIT:
  - Stimulus: accept 0x20, assert `flush` before ack, later ack with 0xFF.
  - Required: state goes to DROP; 0xFF is never presented and `instr_valid` stays 0.
  - Then 0xAA is fetched with data 0x3C and delivered with `instr_pc`=0xAA.
- Wrap and concurrent push/pop: 10 fetches through DEPTH=4, with `instr_ready` toggling so that push and pop coincide -> all 10 delivered in order with no loss or duplication, and pointers wrap twice.
- Async reset in WAIT: accept 0x40, drop reset before ack -> `mem_req` falls in the same cycle, with no clock edge needed. After release, the FIFO is empty and `addr_ready`=1.
